// File: rtl/flash_csr_pkg.sv
// Shared types and constants for the MAX10 on-chip flash CSR access block.
// Build option CSR_WRITE_VERIFY_EN is consumed by onchip_flash_csr_access.
package flash_csr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_POLL_ISSUE,
    ST_POLL_WAIT,
    ST_WR_ISSUE,
    ST_VRFY_ISSUE,
    ST_VRFY_WAIT,
    ST_DONE
  } csr_state_t;

  localparam logic CSR_ADDR_STATUS  = 1'b0;
  localparam logic CSR_ADDR_CONTROL = 1'b1;

  localparam int STATUS_BUSY_LSB = 0;
  localparam int STATUS_BUSY_MSB = 1;

  // Sector/page-erase fields may be cleared here by the integrator.
  localparam logic [31:0] CSR_CTRL_VERIFY_MASK = 32'hFFFF_FFFF;

  function automatic logic status_busy(input logic [31:0] status);
    return status[STATUS_BUSY_MSB:STATUS_BUSY_LSB] != '0;
  endfunction

endpackage

// File: rtl/onchip_flash_csr_access.sv
// Avalon-MM master for the MAX10 flash CSR slave: status/control reads and a busy-polled control write.
// Define CSR_WRITE_VERIFY_EN to read the control register back after every write and flag mismatches.
module onchip_flash_csr_access
  import flash_csr_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_rdsr,
  input  logic        start_rdcr,
  input  logic        start_wrcr,
  input  logic [31:0] wr_data_csr,
  output logic [31:0] rd_data_csr,
  output logic        done_csr,
  output logic        err_csr,
  output logic        avmm_csr_addr,
  output logic        avmm_csr_read,
  output logic        avmm_csr_write,
  output logic [31:0] avmm_csr_writedata,
  input  logic [31:0] avmm_csr_readdata,
  output csr_state_t  o_dbg_state
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int LW = 3;

  csr_state_t    r_state;
  csr_state_t    w_next;
  logic [LW-1:0] r_lat_cnt;
  logic [PW-1:0] r_poll_cnt;
  logic [31:0]   r_wr_data;
  logic [31:0]   r_rd_data;
  logic          r_err;
  logic          r_rd_ctrl;

  logic w_lat_done;
  logic w_busy;
  logic w_poll_last;

  assign w_lat_done  = (r_lat_cnt == LW'(RD_LATENCY - 1));
  assign w_busy      = status_busy(avmm_csr_readdata);
  assign w_poll_last = ((r_poll_cnt + PW'(1)) == PW'(POLL_TIMEOUT));

`ifdef CSR_WRITE_VERIFY_EN
  logic w_verify_err;
  assign w_verify_err = (((avmm_csr_readdata ^ r_wr_data) & CSR_CTRL_VERIFY_MASK) != '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_rdsr || start_rdcr) w_next = ST_RD_ISSUE;
        else if (start_wrcr)          w_next = ST_POLL_ISSUE;
      end
      ST_RD_ISSUE:   w_next = ST_RD_WAIT;
      ST_RD_WAIT:    if (w_lat_done) w_next = ST_DONE;
      ST_POLL_ISSUE: w_next = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (w_lat_done) begin
          if (!w_busy)          w_next = ST_WR_ISSUE;
          else if (w_poll_last) w_next = ST_DONE;
          else                  w_next = ST_POLL_ISSUE;
        end
      end
`ifdef CSR_WRITE_VERIFY_EN
      ST_WR_ISSUE:   w_next = ST_VRFY_ISSUE;
`else
      ST_WR_ISSUE:   w_next = ST_DONE;
`endif
      ST_VRFY_ISSUE: w_next = ST_VRFY_WAIT;
      ST_VRFY_WAIT:  if (w_lat_done) w_next = ST_DONE;
      ST_DONE:       w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // Datapath: latency/poll counters, latched write data, captured read data, error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt  <= '0;
      r_poll_cnt <= '0;
      r_wr_data  <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_rd_ctrl  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_lat_cnt  <= '0;
          r_poll_cnt <= '0;
          r_err      <= 1'b0;
          if (start_rdsr || start_rdcr) r_rd_ctrl <= !start_rdsr;
          else if (start_wrcr)          r_wr_data <= wr_data_csr;
        end
        ST_RD_WAIT: begin
          r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + LW'(1);
          if (w_lat_done) r_rd_data <= avmm_csr_readdata;
        end
        ST_POLL_WAIT: begin
          r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + LW'(1);
          if (w_lat_done) begin
            r_poll_cnt <= r_poll_cnt + PW'(1);
            if (!w_busy)          r_rd_data <= avmm_csr_readdata;
            else if (w_poll_last) r_err     <= 1'b1;
          end
        end
`ifdef CSR_WRITE_VERIFY_EN
        ST_VRFY_WAIT: begin
          r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + LW'(1);
          if (w_lat_done) begin
            r_rd_data <= avmm_csr_readdata;
            r_err     <= w_verify_err;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign avmm_csr_read  = (r_state == ST_RD_ISSUE) || (r_state == ST_POLL_ISSUE) ||
                          (r_state == ST_VRFY_ISSUE);
  assign avmm_csr_write = (r_state == ST_WR_ISSUE);
  assign avmm_csr_addr  = (r_state == ST_RD_ISSUE)   ? r_rd_ctrl :
                          (r_state == ST_WR_ISSUE || r_state == ST_VRFY_ISSUE) ? CSR_ADDR_CONTROL :
                          CSR_ADDR_STATUS;
  assign avmm_csr_writedata = r_wr_data;
  assign rd_data_csr        = r_rd_data;
  assign done_csr           = (r_state == ST_DONE);
  assign err_csr            = (r_state == ST_DONE) && r_err;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_onchip_flash_csr_access.sv
// Scoreboard bench for onchip_flash_csr_access with a behavioural flash CSR slave (RD_LATENCY=1).
// Handshake: a command is one start pulse; its response is the single cycle where done_csr=1.
module tb_onchip_flash_csr_access;
  import flash_csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_rdsr = 1'b0, start_rdcr = 1'b0, start_wrcr = 1'b0;
  logic [31:0] wr_data_csr = '0;
  logic [31:0] rd_data_csr;
  logic        done_csr, err_csr;
  logic        avmm_csr_addr, avmm_csr_read, avmm_csr_write;
  logic [31:0] avmm_csr_writedata;
  logic [31:0] avmm_csr_readdata = 32'hDEAD_BEEF;
  csr_state_t  dbg_state;

  onchip_flash_csr_access #(.RD_LATENCY(1), .POLL_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .start_rdsr(start_rdsr), .start_rdcr(start_rdcr), .start_wrcr(start_wrcr),
    .wr_data_csr(wr_data_csr), .rd_data_csr(rd_data_csr),
    .done_csr(done_csr), .err_csr(err_csr),
    .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
    .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
    .avmm_csr_readdata(avmm_csr_readdata), .o_dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Flash CSR slave model: 1-cycle read latency, garbage on readdata otherwise
  logic [31:0] status_q[$];
  logic [31:0] status_default = '0;
  logic [31:0] ctrl_reg = 32'hFFFF_FFFF;
  logic        ctrl_force_en = 1'b0;
  logic [31:0] ctrl_force = '0;
  int n_st_rd = 0, n_ct_rd = 0, n_wr = 0, n_both = 0, last_rd_cyc = 0;
  logic [31:0] last_wr_data = '0;
  logic        last_wr_addr = 1'b0;

  always @(posedge clk) begin
    avmm_csr_readdata <= 32'hDEAD_BEEF;
    if (avmm_csr_read && avmm_csr_write) n_both <= n_both + 1;
    if (avmm_csr_read) begin
      last_rd_cyc <= cyc;
      if (avmm_csr_addr == CSR_ADDR_CONTROL) begin
        n_ct_rd <= n_ct_rd + 1;
        avmm_csr_readdata <= ctrl_force_en ? ctrl_force : ctrl_reg;
      end else begin
        n_st_rd <= n_st_rd + 1;
        if (status_q.size() > 0) avmm_csr_readdata <= status_q.pop_front();
        else                     avmm_csr_readdata <= status_default;
      end
    end
    if (avmm_csr_write) begin
      n_wr         <= n_wr + 1;
      last_wr_data <= avmm_csr_writedata;
      last_wr_addr <= avmm_csr_addr;
      if (avmm_csr_addr == CSR_ADDR_CONTROL) ctrl_reg <= avmm_csr_writedata;
    end
  end

  // Scoreboard: {err, rd_data} per command, plus expected done cycle (-1 = not timed)
  logic [32:0] exp_q[$];
  int          cyc_q[$];
  int          n_done = 0;

  always @(negedge clk) begin
    if (done_csr) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("done_rd_data", rd_data_csr, e[31:0]);
        chk("done_err", {31'd0, err_csr}, {31'd0, e[32]});
        if (ec >= 0) chk("done_cycle", cyc, ec);
      end
    end
  end

  // Driver tasks
  task automatic pulse(input logic sr, input logic cr, input logic wr,
                       input logic [31:0] wd, output int sc);
    @(negedge clk);
    start_rdsr = sr; start_rdcr = cr; start_wrcr = wr; wr_data_csr = wd;
    sc = cyc;
    @(negedge clk);
    start_rdsr = 1'b0; start_rdcr = 1'b0; start_wrcr = 1'b0; wr_data_csr = '0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int i;
    i = 0;
    while (n_done == d0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (n_done == d0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [32:0] exp_rd_last;
  int sc, d0, st0, ct0, wr0;

  task automatic snap();
    d0 = n_done; st0 = n_st_rd; ct0 = n_ct_rd; wr0 = n_wr;
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] rd, input int c);
    exp_q.push_back({err, rd});
    cyc_q.push_back(c);
    exp_rd_last = {1'b0, rd};
  endtask

  initial begin
    exp_rd_last = '0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_data", rd_data_csr, 32'd0);
    chk("rst_done", {31'd0, done_csr}, 32'd0);
    chk("rst_err", {31'd0, err_csr}, 32'd0);
    chk("rst_read", {31'd0, avmm_csr_read}, 32'd0);
    chk("rst_write", {31'd0, avmm_csr_write}, 32'd0);
    chk("rst_addr", {31'd0, avmm_csr_addr}, 32'd0);
    chk("rst_wdata", avmm_csr_writedata, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: status read, done at start+3
    snap();
    status_q.push_back(32'h0000_0010);
    @(negedge clk);
    expect_resp(1'b0, 32'h0000_0010, cyc + 1 + 3);
    pulse(1'b1, 1'b0, 1'b0, '0, sc);
    wait_done(d0, "t1");
    chk("t1_st_reads", n_st_rd - st0, 1);
    chk("t1_ct_reads", n_ct_rd - ct0, 0);
    chk("t1_read_cycle", last_rd_cyc, sc + 1);

    // 2: control read
    snap();
    ctrl_force_en = 1'b1; ctrl_force = 32'hFFF0_0000;
    @(negedge clk);
    expect_resp(1'b0, 32'hFFF0_0000, cyc + 1 + 3);
    pulse(1'b0, 1'b1, 1'b0, '0, sc);
    wait_done(d0, "t2");
    chk("t2_ct_reads", n_ct_rd - ct0, 1);
    chk("t2_st_reads", n_st_rd - st0, 0);
    ctrl_force_en = 1'b0;

    // 3: control write after 3 busy polls
    snap();
    status_q.push_back(32'h1); status_q.push_back(32'h1); status_q.push_back(32'h1);
    status_q.push_back(32'h0000_0018);
`ifdef CSR_WRITE_VERIFY_EN
    expect_resp(1'b0, 32'h0, -1);
`else
    expect_resp(1'b0, 32'h0000_0018, -1);
`endif
    pulse(1'b0, 1'b0, 1'b1, 32'h0, sc);
    wait_done(d0, "t3");
    chk("t3_st_reads", n_st_rd - st0, 4);
    chk("t3_writes", n_wr - wr0, 1);
    chk("t3_wr_data", last_wr_data, 32'h0);
    chk("t3_wr_addr", {31'd0, last_wr_addr}, 32'd1);

    // 4: status stuck busy -> timeout after 8 polls, no write
    snap();
    status_default = 32'h2;
    expect_resp(1'b1, exp_rd_last[31:0], -1);
    pulse(1'b0, 1'b0, 1'b1, 32'hA5A5_0000, sc);
    wait_done(d0, "t4");
    chk("t4_st_reads", n_st_rd - st0, 8);
    chk("t4_writes", n_wr - wr0, 0);
    status_default = 32'h0;

    // 5: rdsr and wrcr together -> status read only
    snap();
    status_q.push_back(32'h0000_0042);
    @(negedge clk);
    expect_resp(1'b0, 32'h0000_0042, cyc + 1 + 3);
    pulse(1'b1, 1'b0, 1'b1, 32'h5555_0000, sc);
    wait_done(d0, "t5");
    repeat (10) @(negedge clk);
    chk("t5_dones", n_done - d0, 1);
    chk("t5_writes", n_wr - wr0, 0);
    chk("t5_st_reads", n_st_rd - st0, 1);

    // 6: reset during POLL_WAIT aborts silently
    snap();
    status_default = 32'h1;
    pulse(1'b0, 1'b0, 1'b1, 32'h1234_5678, sc);
    @(posedge clk);
    #2;
    chk("t6_in_poll_wait", {28'd0, dbg_state}, {28'd0, ST_POLL_WAIT});
    reset = 1'b0;
    #1;
    chk("t6_rd_data", rd_data_csr, 32'd0);
    chk("t6_wdata", avmm_csr_writedata, 32'd0);
    chk("t6_strobes", {30'd0, avmm_csr_read, avmm_csr_write}, 32'd0);
    chk("t6_done_err", {30'd0, done_csr, err_csr}, 32'd0);
    repeat (3) @(negedge clk);
    status_default = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", n_done - d0, 0);
    ctrl_force_en = 1'b1; ctrl_force = 32'h0BAD_F00D;
    @(negedge clk);
    expect_resp(1'b0, 32'h0BAD_F00D, cyc + 1 + 3);
    pulse(1'b0, 1'b1, 1'b0, '0, sc);
    wait_done(d0, "t6");
    ctrl_force_en = 1'b0;

`ifdef CSR_WRITE_VERIFY_EN
    // 7: verify readback mismatch
    snap();
    ctrl_force_en = 1'b1; ctrl_force = 32'h00F0_0001;
    expect_resp(1'b1, 32'h00F0_0001, -1);
    pulse(1'b0, 1'b0, 1'b1, 32'h00F0_0000, sc);
    wait_done(d0, "t7");
    chk("t7_wr_data", last_wr_data, 32'h00F0_0000);
    ctrl_force_en = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("no_read_write_overlap", n_both, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
